cvxif_pau_arbiter: RTL and testbench

Shares one `cvxif_pau` coprocessor between two CV-X-IF requesters (cores 0 and 1). It sits between both cores' coprocessor ports and the single PAU. It grants the PAU round-robin and keeps one instruction in flight at a time. It routes the register and result phases back to the requester that owns the in-flight instruction.

---
 rtl/cvxif_pau_arbiter_pkg.sv | 11 +
 rtl/cvxif_pau_arbiter_if.sv | 34 +++
 rtl/cvxif_pau_arbiter_rr_arb2.sv | 14 +
 rtl/cvxif_pau_arbiter.sv | 109 ++++++++++
 tb/tb_cvxif_pau_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cvxif_pau_arbiter_pkg.sv
// Shared definitions for the two-requester CV-X-IF PAU arbiter.
package cvxif_pau_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_REG    = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam int XLEN_DEF = 32;

endpackage

// File: rtl/cvxif_pau_arbiter_if.sv
// One CV-X-IF coprocessor port set (issue, register and result channels).
interface cvxif_pau_arbiter_if #(parameter int XLEN = 32);

  logic            issue_valid;
  logic            issue_ready;
  logic [XLEN-1:0] issue_req_instr;
  logic            issue_resp_accept;
  logic            issue_resp_writeback;
  logic [1:0]      issue_resp_register_read;
  logic            register_valid;
  logic            register_ready;
  logic [XLEN-1:0] register_rs0;
  logic [XLEN-1:0] register_rs1;
  logic [1:0]      register_rs_valid;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result_data;

  // master = core side (drives issue), slave = coprocessor side
  modport master (
    output issue_valid, issue_req_instr, register_valid, register_rs0,
           register_rs1, register_rs_valid, result_ready,
    input  issue_ready, issue_resp_accept, issue_resp_writeback,
           issue_resp_register_read, register_ready, result_valid, result_data
  );

  modport slave (
    input  issue_valid, issue_req_instr, register_valid, register_rs0,
           register_rs1, register_rs_valid, result_ready,
    output issue_ready, issue_resp_accept, issue_resp_writeback,
           issue_resp_register_read, register_ready, result_valid, result_data
  );

endinterface

// File: rtl/cvxif_pau_arbiter_rr_arb2.sv
// Two-request round-robin pick: on contention the pointer wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) gnt_idx = ptr;
    else if (req[1])  gnt_idx = 1'b1;
  end

endmodule

// File: rtl/cvxif_pau_arbiter.sv
// Shares one PAU between two CV-X-IF requesters, one instruction in flight.
module cvxif_pau_arbiter
  import cvxif_pau_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  cvxif_pau_arbiter_if.slave   r0,
  cvxif_pau_arbiter_if.slave   r1,
  cvxif_pau_arbiter_if.master  pau
);

  logic [1:0] state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       rr_q, rr_d;
  logic       arb_gnt;

  logic            own_issue_valid, own_reg_valid, own_result_ready;
  logic [XLEN-1:0] own_instr, own_rs0, own_rs1;
  logic [1:0]      own_rs_valid;
  logic            in_issue, in_reg, in_res;

  rr_arb2 u_rr_arb2 (
    .req     ({r1.issue_valid, r0.issue_valid}),
    .ptr     (rr_q),
    .gnt_idx (arb_gnt)
  );

  assign in_issue = (state_q == ST_ISSUE);
  assign in_reg   = (state_q == ST_REG);
  assign in_res   = (state_q == ST_RESULT);

  assign own_issue_valid  = gnt_q ? r1.issue_valid       : r0.issue_valid;
  assign own_instr        = gnt_q ? r1.issue_req_instr   : r0.issue_req_instr;
  assign own_reg_valid    = gnt_q ? r1.register_valid    : r0.register_valid;
  assign own_rs0          = gnt_q ? r1.register_rs0      : r0.register_rs0;
  assign own_rs1          = gnt_q ? r1.register_rs1      : r0.register_rs1;
  assign own_rs_valid     = gnt_q ? r1.register_rs_valid : r0.register_rs_valid;
  assign own_result_ready = gnt_q ? r1.result_ready      : r0.result_ready;

  // PAU side: each channel only carries the owner's request in its own phase
  assign pau.issue_valid       = in_issue & own_issue_valid;
  assign pau.issue_req_instr   = in_issue ? own_instr : '0;
  assign pau.register_valid    = in_reg & own_reg_valid;
  assign pau.register_rs0      = in_reg ? own_rs0 : '0;
  assign pau.register_rs1      = in_reg ? own_rs1 : '0;
  assign pau.register_rs_valid = in_reg ? own_rs_valid : 2'b00;
  assign pau.result_ready      = in_res & own_result_ready;

  assign r0.issue_ready              = in_issue & ~gnt_q & pau.issue_ready;
  assign r0.issue_resp_accept        = in_issue & ~gnt_q & pau.issue_resp_accept;
  assign r0.issue_resp_writeback     = in_issue & ~gnt_q & pau.issue_resp_writeback;
  assign r0.issue_resp_register_read = {2{in_issue & ~gnt_q}} & pau.issue_resp_register_read;
  assign r0.register_ready           = in_reg & ~gnt_q & pau.register_ready;
  assign r0.result_valid             = in_res & ~gnt_q & pau.result_valid;
  assign r0.result_data              = (in_res & ~gnt_q) ? pau.result_data : '0;

  assign r1.issue_ready              = in_issue & gnt_q & pau.issue_ready;
  assign r1.issue_resp_accept        = in_issue & gnt_q & pau.issue_resp_accept;
  assign r1.issue_resp_writeback     = in_issue & gnt_q & pau.issue_resp_writeback;
  assign r1.issue_resp_register_read = {2{in_issue & gnt_q}} & pau.issue_resp_register_read;
  assign r1.register_ready           = in_reg & gnt_q & pau.register_ready;
  assign r1.result_valid             = in_res & gnt_q & pau.result_valid;
  assign r1.result_data              = (in_res & gnt_q) ? pau.result_data : '0;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (r0.issue_valid | r1.issue_valid) begin
          gnt_d   = arb_gnt;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // a withdrawn request abandons the grant without moving the pointer
        if (!own_issue_valid) begin
          state_d = ST_IDLE;
        end else if (pau.issue_ready) begin
          rr_d    = ~gnt_q;
          state_d = pau.issue_resp_accept ? ST_REG : ST_IDLE;
        end
      end
      ST_REG: begin
        if (own_reg_valid & pau.register_ready) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (pau.result_valid & own_result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_cvxif_pau_arbiter.sv
// Directed bench for cvxif_pau_arbiter; the bench plays both cores and the PAU.
module tb_cvxif_pau_arbiter;
  import cvxif_pau_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk = ~clk;

  cvxif_pau_arbiter_if #(.XLEN(32)) r0_if ();
  cvxif_pau_arbiter_if #(.XLEN(32)) r1_if ();
  cvxif_pau_arbiter_if #(.XLEN(32)) pau_if ();

  cvxif_pau_arbiter #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .r0  (r0_if),
    .r1  (r1_if),
    .pau (pau_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iv(input bit i, input logic v, input logic [31:0] instr);
    if (i) begin r1_if.issue_valid = v; r1_if.issue_req_instr = instr; end
    else   begin r0_if.issue_valid = v; r0_if.issue_req_instr = instr; end
  endtask

  task automatic set_reg(input bit i, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (i) begin
      r1_if.register_valid = v; r1_if.register_rs0 = a; r1_if.register_rs1 = b;
      r1_if.register_rs_valid = {v, v};
    end else begin
      r0_if.register_valid = v; r0_if.register_rs0 = a; r0_if.register_rs1 = b;
      r0_if.register_rs_valid = {v, v};
    end
  endtask

  task automatic set_rrdy(input bit i, input logic v);
    if (i) r1_if.result_ready = v; else r0_if.result_ready = v;
  endtask

  function automatic logic get_ir(input bit i);
    return i ? r1_if.issue_ready : r0_if.issue_ready;
  endfunction
  function automatic logic get_acc(input bit i);
    return i ? r1_if.issue_resp_accept : r0_if.issue_resp_accept;
  endfunction
  function automatic logic get_rdy(input bit i);
    return i ? r1_if.register_ready : r0_if.register_ready;
  endfunction
  function automatic logic [31:0] get_resd(input bit i);
    return i ? r1_if.result_data : r0_if.result_data;
  endfunction

  // Entry: FSM in IDLE with owner's issue_valid already raised.
  task automatic do_txn(input bit o, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input bit acc,
                        input int stall);
    #1 chk("idle_pau_iv", pau_if.issue_valid, 0);
    step();
    pau_if.issue_ready = 1'b1;
    pau_if.issue_resp_accept = acc;
    pau_if.issue_resp_writeback = acc;
    pau_if.issue_resp_register_read = acc ? 2'b11 : 2'b00;
    #1;
    chk("gnt", dut.gnt_q, o);
    chk("pau_instr", pau_if.issue_req_instr, instr);
    chk("own_issue_ready", get_ir(o), 1);
    chk("own_accept", get_acc(o), acc);
    chk("oth_issue_ready", get_ir(!o), 0);
    chk("oth_accept", get_acc(!o), 0);
    step();
    set_iv(o, 1'b0, 32'h0);
    pau_if.issue_ready = 1'b0;
    pau_if.issue_resp_accept = 1'b0;
    pau_if.issue_resp_writeback = 1'b0;
    pau_if.issue_resp_register_read = 2'b00;
    chk("rr_after_issue", dut.rr_q, !o);
    if (!acc) begin
      #1;
      chk("rej_idle", dut.state_q, ST_IDLE);
      chk("rej_pau_regv", pau_if.register_valid, 0);
    end else begin
      set_reg(o, 1'b1, a, b);
      pau_if.register_ready = 1'b1;
      #1;
      chk("reg_state", dut.state_q, ST_REG);
      chk("pau_rs0", pau_if.register_rs0, a);
      chk("pau_rs1", pau_if.register_rs1, b);
      chk("own_reg_ready", get_rdy(o), 1);
      chk("oth_reg_ready", get_rdy(!o), 0);
      step();
      set_reg(o, 1'b0, 32'h0, 32'h0);
      pau_if.register_ready = 1'b0;
      pau_if.result_valid = 1'b1;
      pau_if.result_data = res;
      set_rrdy(o, stall == 0);
      if (stall > 0) set_iv(!o, 1'b1, 32'h66);
      #1;
      chk("res_data", get_resd(o), res);
      chk("oth_res_data", get_resd(!o), 0);
      for (int k = 0; k < stall; k++) begin
        step();
        #1;
        chk("stall_state", dut.state_q, ST_RESULT);
        chk("stall_data", get_resd(o), res);
        chk("stall_oth_ir", get_ir(!o), 0);
      end
      set_rrdy(o, 1'b1);
      #1 chk("pau_res_ready", pau_if.result_ready, 1);
      step();
      pau_if.result_valid = 1'b0;
      pau_if.result_data = 32'h0;
      set_rrdy(o, 1'b0);
      #1 chk("done_idle", dut.state_q, ST_IDLE);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_iv(0, 0, 0); set_iv(1, 0, 0);
    set_reg(0, 0, 0, 0); set_reg(1, 0, 0, 0);
    set_rrdy(0, 0); set_rrdy(1, 0);
    pau_if.issue_ready = 0; pau_if.issue_resp_accept = 0;
    pau_if.issue_resp_writeback = 0; pau_if.issue_resp_register_read = 0;
    pau_if.register_ready = 0; pau_if.result_valid = 0; pau_if.result_data = 0;

    // reset state
    step(); step();
    chk("rst_state", dut.state_q, ST_IDLE);
    chk("rst_gnt", dut.gnt_q, 0);
    chk("rst_rr", dut.rr_q, 0);
    chk("rst_pau_iv", pau_if.issue_valid, 0);
    chk("rst_r0_ir", r0_if.issue_ready, 0);
    rst = 1'b1;
    step();

    // basic r0 transaction
    set_iv(0, 1, 32'h0000_000B);
    do_txn(0, 32'h0000_000B, 32'd5, 32'd7, 32'd12, 1, 0);
    chk("t1_rr", dut.rr_q, 1);

    // rejected r1 instruction
    set_iv(1, 1, 32'h0000_1234);
    do_txn(1, 32'h0000_1234, 0, 0, 0, 0, 0);

    // three simultaneous requests alternate r0, r1, r0
    for (int r = 0; r < 3; r++) begin
      set_iv(0, 1, 32'h100 + r);
      set_iv(1, 1, 32'h200 + r);
      do_txn(r[0], r[0] ? 32'h200 + r : 32'h100 + r, r, r + 1, 2 * r + 1, 1, 0);
    end
    set_iv(1, 0, 0);

    // result stall with the other requester waiting, then it is served
    set_iv(0, 1, 32'h55);
    do_txn(0, 32'h55, 32'd1, 32'd2, 32'hABCD, 1, 5);
    do_txn(1, 32'h66, 32'd3, 32'd4, 32'h1234, 1, 0);

    // reset while r1 is in the register phase
    set_iv(1, 1, 32'h77);
    step();
    pau_if.issue_ready = 1; pau_if.issue_resp_accept = 1;
    step();
    set_iv(1, 0, 0);
    pau_if.issue_ready = 0; pau_if.issue_resp_accept = 0;
    set_reg(1, 1, 32'h9, 32'hA);
    pau_if.register_ready = 1;
    #1 chk("pre_rst_reg", dut.state_q, ST_REG);
    rst = 1'b0;
    step();
    chk("mid_rst_state", dut.state_q, ST_IDLE);
    chk("mid_rst_gnt", dut.gnt_q, 0);
    chk("mid_rst_rr", dut.rr_q, 0);
    chk("mid_rst_pau_regv", pau_if.register_valid, 0);
    chk("mid_rst_r1_rdy", r1_if.register_ready, 0);
    chk("mid_rst_pau_rs0", pau_if.register_rs0, 0);
    rst = 1'b1;
    set_reg(1, 0, 0, 0);
    pau_if.register_ready = 0;
    set_iv(1, 1, 32'h88);
    do_txn(1, 32'h88, 32'd10, 32'd20, 32'd30, 1, 0);

    // owner withdraws before issue handshake; pending r1 goes next
    set_iv(0, 1, 32'hAA);
    set_iv(1, 1, 32'hBB);
    step();
    #1;
    chk("drop_gnt", dut.gnt_q, 0);
    chk("drop_r0_ir", r0_if.issue_ready, 0);
    step();
    set_iv(0, 0, 0);
    #1 chk("drop_pau_iv", pau_if.issue_valid, 0);
    step();
    chk("drop_idle", dut.state_q, ST_IDLE);
    chk("drop_rr", dut.rr_q, 0);
    do_txn(1, 32'hBB, 32'd1, 32'd1, 32'd2, 1, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
